pipe_stall_ctrl: RTL and testbench

- Consumes hazard flags: the EX-load/ID-use flag, the ID-stage branch/jump redirect, the data-memory wait and the EX-stage mult/div issue.
- Drives per-register enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB in the 5-stage MIPS pipeline.
- Owns the multi-cycle mult/div occupancy state machine and saturating stall/flush performance counters.

---
 rtl/pipe_stall_ctrl.sv | 73 +++++++
 tb/tb_pipe_stall_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: 5-stage pipeline stall/flush control with mult/div occupancy FSM and saturating perf counters.
module pipe_stall_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             md_start,
    input  logic             md_is_div,
    output logic             PC_en,
    output logic             D_en,
    output logic             D_flush,
    output logic             E_en,
    output logic             E_flush,
    output logic             M_en,
    output logic             M_flush,
    output logic             W_en,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] MD_WAIT = 1'b1;
    localparam logic [5:0] MUL_LD  = 6'(MUL_LAT - 2);
    localparam logic [5:0] DIV_LD  = 6'(DIV_LAT - 2);

    logic [0:0] state;
    logic [5:0] md_cnt;
    logic       mem_frz, md_frz, lu_frz, redir;

    // each rule is masked by every higher-priority rule, and reset masks all of them
    always_comb begin
        mem_frz = !rst && mem_busy;
        md_frz  = !rst && !mem_busy && (state == RUN ? md_start : md_cnt != 6'd0);
        lu_frz  = !rst && !mem_busy && !md_frz && load_use;
        redir   = !rst && !mem_busy && !md_frz && !load_use && branch_taken;
        PC_en   = !(mem_frz || md_frz || lu_frz);
        D_en    = PC_en;
        E_en    = !(mem_frz || md_frz);
        M_en    = !mem_frz;
        W_en    = !mem_frz;
        D_flush = redir;
        E_flush = lu_frz;
        M_flush = md_frz;
        md_busy = !rst && state == MD_WAIT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            md_cnt    <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == RUN) begin
                if (md_start && !mem_busy) begin
                    state  <= MD_WAIT;
                    md_cnt <= md_is_div ? DIV_LD : MUL_LD;
                end
            end else if (md_cnt != 6'd0) begin
                md_cnt <= md_cnt - 6'd1;
            end else if (!mem_busy) begin
                state <= RUN;
            end
            if (!PC_en && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if ((D_flush || E_flush || M_flush) && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed scenario tests for pipe_stall_ctrl; a CNT_W=4 copy shares the stimulus to check saturation.
module tb_pipe_stall_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0, lu = 1'b0, bt = 1'b0, mb = 1'b0, ms = 1'b0, md = 1'b0;
    logic pc_en, d_en, d_fl, e_en, e_fl, m_en, m_fl, w_en, busy;
    logic [31:0] stall_cnt, flush_cnt;
    logic s_pc, s_d, s_df, s_e, s_ef, s_m, s_mf, s_w, s_busy;
    logic [3:0] stall4, flush4;
    logic [8:0] o;
    int checks = 0;
    int fails  = 0;

    // o = {PC_en, D_en, D_flush, E_en, E_flush, M_en, M_flush, W_en, md_busy}
    localparam logic [8:0] NORM   = 9'b110101010;
    localparam logic [8:0] LU     = 9'b000111010;
    localparam logic [8:0] BR     = 9'b111101010;
    localparam logic [8:0] MD_RUN = 9'b000001110;
    localparam logic [8:0] MD_WT  = 9'b000001111;
    localparam logic [8:0] REL    = 9'b110101011;
    localparam logic [8:0] MEM_R  = 9'b000000000;
    localparam logic [8:0] MEM_W  = 9'b000000001;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .load_use(lu), .branch_taken(bt), .mem_busy(mb),
        .md_start(ms), .md_is_div(md), .PC_en(pc_en), .D_en(d_en), .D_flush(d_fl),
        .E_en(e_en), .E_flush(e_fl), .M_en(m_en), .M_flush(m_fl), .W_en(w_en),
        .md_busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stall_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .load_use(lu), .branch_taken(bt), .mem_busy(mb),
        .md_start(ms), .md_is_div(md), .PC_en(s_pc), .D_en(s_d), .D_flush(s_df),
        .E_en(s_e), .E_flush(s_ef), .M_en(s_m), .M_flush(s_mf), .W_en(s_w),
        .md_busy(s_busy), .stall_cnt(stall4), .flush_cnt(flush4)
    );

    assign o = {pc_en, d_en, d_fl, e_en, e_fl, m_en, m_fl, w_en, busy};

    // inputs change at negedge; outputs are sampled 1ns later, well clear of posedge
    task automatic drv(input logic r, l, b, m, s, d);
        @(negedge clk);
        rst = r; lu = l; bt = b; mb = m; ms = s; md = d;
        #1;
    endtask

    task automatic do_reset();
        drv(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drv(1, 1, 1, 1, 1, 1);
        checks++; if (o !== NORM) begin fails++; $display("FAIL reset_forced: got %b expected %b", o, NORM); end
        for (int i = 0; i < 5; i++) begin
            drv(0, 0, 0, 0, 0, 0);
            checks++; if (o !== NORM) begin fails++; $display("FAIL idle_%0d: got %b expected %b", i, o, NORM); end
        end
        checks++; if (stall_cnt !== 32'd0) begin fails++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
        checks++; if (flush_cnt !== 32'd0) begin fails++; $display("FAIL reset_flush: got %0d expected 0", flush_cnt); end
        checks++; if (stall4 !== 4'd0) begin fails++; $display("FAIL reset_stall4: got %0d expected 0", stall4); end
    endtask

    task automatic test_load_use();
        drv(0, 1, 0, 0, 0, 0);
        checks++; if (o !== LU) begin fails++; $display("FAIL load_use: got %b expected %b", o, LU); end
        drv(0, 0, 0, 0, 0, 0);
        checks++; if (o !== NORM) begin fails++; $display("FAIL lu_after: got %b expected %b", o, NORM); end
        checks++; if (stall_cnt !== 32'd1) begin fails++; $display("FAIL lu_stall: got %0d expected 1", stall_cnt); end
        checks++; if (flush_cnt !== 32'd1) begin fails++; $display("FAIL lu_flush: got %0d expected 1", flush_cnt); end
    endtask

    task automatic test_lu_branch();
        drv(0, 1, 1, 0, 0, 0);
        checks++; if (o !== LU) begin fails++; $display("FAIL lu_br_both: got %b expected %b", o, LU); end
        drv(0, 0, 1, 0, 0, 0);
        checks++; if (o !== BR) begin fails++; $display("FAIL br_only: got %b expected %b", o, BR); end
        drv(0, 0, 0, 0, 0, 0);
        checks++; if (stall_cnt !== 32'd2) begin fails++; $display("FAIL lubr_stall: got %0d expected 2", stall_cnt); end
        checks++; if (flush_cnt !== 32'd3) begin fails++; $display("FAIL lubr_flush: got %0d expected 3", flush_cnt); end
    endtask

    task automatic test_divide();
        do_reset();
        drv(0, 0, 0, 0, 1, 1);
        checks++; if (o !== MD_RUN) begin fails++; $display("FAIL div_start: got %b expected %b", o, MD_RUN); end
        for (int i = 0; i < 30; i++) begin
            drv(0, 0, 0, 0, 1, 1);
            checks++; if (o !== MD_WT) begin fails++; $display("FAIL div_freeze cyc %0d: got %b expected %b", i + 2, o, MD_WT); end
        end
        drv(0, 0, 0, 0, 1, 1);
        checks++; if (o !== REL) begin fails++; $display("FAIL div_release: got %b expected %b", o, REL); end
        drv(0, 0, 0, 0, 0, 0);
        checks++; if (o !== NORM) begin fails++; $display("FAIL div_after: got %b expected %b", o, NORM); end
        checks++; if (stall_cnt !== 32'd31) begin fails++; $display("FAIL div_stall: got %0d expected 31", stall_cnt); end
        checks++; if (flush_cnt !== 32'd31) begin fails++; $display("FAIL div_flush: got %0d expected 31", flush_cnt); end
    endtask

    task automatic test_multiply();
        do_reset();
        drv(0, 0, 0, 0, 1, 0);
        checks++; if (o !== MD_RUN) begin fails++; $display("FAIL mul_start: got %b expected %b", o, MD_RUN); end
        for (int i = 0; i < 2; i++) begin
            drv(0, 0, 0, 0, 1, 0);
            checks++; if (o !== MD_WT) begin fails++; $display("FAIL mul_freeze cyc %0d: got %b expected %b", i + 2, o, MD_WT); end
        end
        drv(0, 1, 0, 0, 1, 0);
        checks++; if (o !== (LU | 9'b1)) begin fails++; $display("FAIL mul_release_lu: got %b expected %b", o, LU | 9'b1); end
        drv(0, 0, 0, 0, 0, 0);
        checks++; if (o !== NORM) begin fails++; $display("FAIL mul_after: got %b expected %b", o, NORM); end
        checks++; if (stall_cnt !== 32'd4) begin fails++; $display("FAIL mul_stall: got %0d expected 4", stall_cnt); end
    endtask

    task automatic test_mem_busy();
        do_reset();
        drv(0, 0, 0, 1, 1, 0);
        checks++; if (o !== MEM_R) begin fails++; $display("FAIL mem_run_start: got %b expected %b", o, MEM_R); end
        drv(0, 0, 0, 0, 1, 0);
        checks++; if (o !== MD_RUN) begin fails++; $display("FAIL mem_md_start: got %b expected %b", o, MD_RUN); end
        drv(0, 0, 0, 0, 1, 0);
        checks++; if (o !== MD_WT) begin fails++; $display("FAIL mem_md_cnt2: got %b expected %b", o, MD_WT); end
        for (int i = 0; i < 3; i++) begin
            drv(0, 1, 1, 1, 1, 0);
            checks++; if (o !== MEM_W) begin fails++; $display("FAIL mem_freeze %0d: got %b expected %b", i, o, MEM_W); end
        end
        drv(0, 0, 0, 0, 1, 0);
        checks++; if (o !== REL) begin fails++; $display("FAIL mem_release: got %b expected %b", o, REL); end
        drv(0, 0, 0, 0, 0, 0);
        checks++; if (o !== NORM) begin fails++; $display("FAIL mem_after: got %b expected %b", o, NORM); end
        checks++; if (stall_cnt !== 32'd6) begin fails++; $display("FAIL mem_stall: got %0d expected 6", stall_cnt); end
        checks++; if (flush_cnt !== 32'd2) begin fails++; $display("FAIL mem_flush: got %0d expected 2", flush_cnt); end
    endtask

    task automatic test_rst_abort();
        do_reset();
        for (int i = 0; i < 4; i++) drv(0, 0, 0, 0, 1, 1);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy_pre: got %b expected 1", busy); end
        drv(1, 0, 0, 0, 1, 1);
        checks++; if (o !== NORM) begin fails++; $display("FAIL abort_rst: got %b expected %b", o, NORM); end
        drv(0, 0, 0, 0, 1, 1);
        checks++; if (o !== MD_RUN) begin fails++; $display("FAIL abort_restart: got %b expected %b", o, MD_RUN); end
        checks++; if (stall_cnt !== 32'd0) begin fails++; $display("FAIL abort_stall0: got %0d expected 0", stall_cnt); end
        checks++; if (flush_cnt !== 32'd0) begin fails++; $display("FAIL abort_flush0: got %0d expected 0", flush_cnt); end
        for (int i = 0; i < 30; i++) begin
            drv(0, 0, 0, 0, 1, 1);
            checks++; if (o !== MD_WT) begin fails++; $display("FAIL abort_freeze cyc %0d: got %b expected %b", i + 2, o, MD_WT); end
        end
        drv(0, 0, 0, 0, 1, 1);
        checks++; if (o !== REL) begin fails++; $display("FAIL abort_release: got %b expected %b", o, REL); end
        drv(0, 0, 0, 0, 0, 0);
        checks++; if (stall_cnt !== 32'd31) begin fails++; $display("FAIL abort_stall: got %0d expected 31", stall_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) drv(0, 1, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0);
        checks++; if (stall4 !== 4'd15) begin fails++; $display("FAIL sat_stall4: got %0d expected 15", stall4); end
        checks++; if (flush4 !== 4'd15) begin fails++; $display("FAIL sat_flush4: got %0d expected 15", flush4); end
        checks++; if (stall_cnt !== 32'd20) begin fails++; $display("FAIL sat_stall32: got %0d expected 20", stall_cnt); end
        checks++; if (flush_cnt !== 32'd20) begin fails++; $display("FAIL sat_flush32: got %0d expected 20", flush_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_lu_branch();
        test_divide();
        test_multiply();
        test_mem_busy();
        test_rst_abort();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
